// File: rtl/seg_pkg.sv
// Shared types and constants for the stopwatch seven-segment controller.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package seg_pkg;

   localparam int unsigned DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes decode to a blank digit.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/stopwatch_seg_ctrl.sv
// MM:SS stopwatch with run/pause control and a registered, multiplexed
// common-anode seven-segment driver.
module stopwatch_seg_ctrl #(
   parameter int unsigned DIGITS = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              tick_sec,
   input  logic              tick_scan,
   input  logic              start_stop,
   input  logic              clear,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              dp,
   output logic              running,
   output logic [15:0]       bcd_time
);

   import seg_pkg::*;

   sw_state_t         state_q, state_d;
   logic [3:0]        sec_lo_q, sec_lo_d;
   logic [3:0]        sec_hi_q, sec_hi_d;
   logic [3:0]        min_lo_q, min_lo_d;
   logic [3:0]        min_hi_q, min_hi_d;
   logic [1:0]        idx_q, idx_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              running_q, running_d;
   logic [3:0]        sel_digit;

   // clear has priority over start_stop
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else if (start_stop) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Counting looks at the registered state, so a stop pulse still counts
   // its coincident tick and a start pulse does not.
   always_comb begin
      sec_lo_d = sec_lo_q;
      sec_hi_d = sec_hi_q;
      min_lo_d = min_lo_q;
      min_hi_d = min_hi_q;
      if (clear) begin
         sec_lo_d = 4'd0;
         sec_hi_d = 4'd0;
         min_lo_d = 4'd0;
         min_hi_d = 4'd0;
      end else if (state_q == RUN && tick_sec) begin
         if (sec_lo_q == 4'd9) begin
            sec_lo_d = 4'd0;
            if (sec_hi_q == 4'd5) begin
               sec_hi_d = 4'd0;
               if (min_lo_q == 4'd9) begin
                  min_lo_d = 4'd0;
                  min_hi_d = (min_hi_q == 4'd5) ? 4'd0 : min_hi_q + 4'd1;
               end else begin
                  min_lo_d = min_lo_q + 4'd1;
               end
            end else begin
               sec_hi_d = sec_hi_q + 4'd1;
            end
         end else begin
            sec_lo_d = sec_lo_q + 4'd1;
         end
      end
   end

   always_comb begin
      sel_digit = sec_lo_q;
      unique case (idx_q)
         2'd0: sel_digit = sec_lo_q;
         2'd1: sel_digit = sec_hi_q;
         2'd2: sel_digit = min_lo_q;
         2'd3: sel_digit = min_hi_q;
      endcase
   end

   bcd_to_seg u_bcd_to_seg (
      .bcd_i (sel_digit),
      .seg_o (seg_d)
   );

   // Display registers are all built from the current index and count so
   // an, seg and dp switch on the same edge.
   always_comb begin
      idx_d = tick_scan ? idx_q + 2'd1 : idx_q;
      for (int i = 0; i < DIGITS; i++) begin
         an_d[i] = (idx_q != 2'(i));
      end
      dp_d      = ~((idx_q == 2'd2) && (state_q != IDLE));
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         sec_lo_q  <= 4'd0;
         sec_hi_q  <= 4'd0;
         min_lo_q  <= 4'd0;
         min_hi_q  <= 4'd0;
         idx_q     <= 2'd0;
         an_q      <= '1;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sec_lo_q  <= sec_lo_d;
         sec_hi_q  <= sec_hi_d;
         min_lo_q  <= min_lo_d;
         min_hi_q  <= min_hi_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         running_q <= running_d;
      end
   end

   assign an       = an_q;
   assign seg      = seg_q;
   assign dp       = dp_q;
   assign running  = running_q;
   assign bcd_time = {min_hi_q, min_lo_q, sec_hi_q, sec_lo_q};

endmodule

// File: tb/tb_stopwatch_seg_ctrl.sv
// Directed self-checking bench for stopwatch_seg_ctrl.
module tb_stopwatch_seg_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        tick_sec;
   logic        tick_scan;
   logic        start_stop;
   logic        clear;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        running;
   logic [15:0] bcd_time;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stopwatch_seg_ctrl #(
      .DIGITS (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .tick_sec   (tick_sec),
      .tick_scan  (tick_scan),
      .start_stop (start_stop),
      .clear      (clear),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .running    (running),
      .bcd_time   (bcd_time)
   );

   task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
   task automatic cycle(input logic ss, input logic clr, input logic ts, input logic tsc);
      start_stop = ss;
      clear      = clr;
      tick_sec   = ts;
      tick_scan  = tsc;
      @(posedge clk);
      #1;
      start_stop = 1'b0;
      clear      = 1'b0;
      tick_sec   = 1'b0;
      tick_scan  = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   logic [3:0] an_exp [4];

   initial begin
      an_exp[0] = 4'b1101;
      an_exp[1] = 4'b1011;
      an_exp[2] = 4'b0111;
      an_exp[3] = 4'b1110;
      rstn = 1'b0;
      start_stop = 1'b0; clear = 1'b0; tick_sec = 1'b0; tick_scan = 1'b0;
      @(negedge clk);

      // Reset and idle scan
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("rst_an", 16'(an), 16'hF);
      check_val("rst_seg", 16'(seg), 16'h7F);
      check_val("rst_dp", 16'(dp), 16'h1);
      check_val("rst_running", 16'(running), 16'h0);
      check_val("rst_bcd", bcd_time, 16'h0000);
      rstn = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("first_an", 16'(an), 16'hE);
      check_val("first_seg", 16'(seg), 16'h40);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         check_val("scan_an", 16'(an), 16'(an_exp[i]));
         check_val("scan_seg", 16'(seg), 16'h40);
         check_val("scan_dp", 16'(dp), 16'h1);
      end

      // Idle ignores ticks
      ticks(3);
      check_val("idle_no_count", bcd_time, 16'h0000);

      // Run and carry
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("run_running", 16'(running), 16'h1);
      ticks(70);
      check_val("carry_bcd", bcd_time, 16'h0110);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("idx2_an", 16'(an), 16'hB);
      check_val("idx2_seg", 16'(seg), 16'h79);
      check_val("idx2_dp", 16'(dp), 16'h0);

      // Wrap (index stays at 2)
      ticks(3529);
      check_val("pre_wrap_bcd", bcd_time, 16'h5959);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("min_lo9_seg", 16'(seg), 16'h10);
      ticks(1);
      check_val("wrap_bcd", bcd_time, 16'h0000);
      check_val("wrap_running", 16'(running), 16'h1);

      // Pause and same-cycle events
      ticks(12);
      check_val("pre_pause_bcd", bcd_time, 16'h0012);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_val("stop_tick_bcd", bcd_time, 16'h0013);
      check_val("pause_running", 16'(running), 16'h0);
      ticks(3);
      check_val("pause_hold_bcd", bcd_time, 16'h0013);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_val("start_tick_bcd", bcd_time, 16'h0013);
      check_val("resume_running", 16'(running), 16'h1);
      ticks(1);
      check_val("resume_count_bcd", bcd_time, 16'h0014);

      // Clear priority
      ticks(213);
      check_val("pre_clear_bcd", bcd_time, 16'h0347);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check_val("clear_bcd", bcd_time, 16'h0000);
      check_val("clear_running", 16'(running), 16'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("clear_dp_idx2", 16'(dp), 16'h1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         check_val("clear_dp_scan", 16'(dp), 16'h1);
      end
      check_val("clear_stays_idle", 16'(running), 16'h0);

      // Reset mid-run at 02:25, index 3
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(145);
      check_val("pre_rst_bcd", bcd_time, 16'h0225);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("idx3_an", 16'(an), 16'h7);
      check_val("idx3_seg", 16'(seg), 16'h40);
      rstn = 1'b0;
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check_val("mid_rst_an", 16'(an), 16'hF);
      check_val("mid_rst_seg", 16'(seg), 16'h7F);
      check_val("mid_rst_dp", 16'(dp), 16'h1);
      check_val("mid_rst_running", 16'(running), 16'h0);
      check_val("mid_rst_bcd", bcd_time, 16'h0000);
      rstn = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("post_rst_an", 16'(an), 16'hE);
      check_val("post_rst_seg", 16'(seg), 16'h40);
      check_val("post_rst_running", 16'(running), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_seg_ctrl.md
# stopwatch_seg_ctrl

MM:SS stopwatch with a 4-digit multiplexed seven-segment driver. Sits directly downstream of the tick-enable divider chain. Its 1 Hz enable (`tick_sec`) advances the time count, and its 1 kHz enable (`tick_scan`) steps the digit scan. Outputs drive the board's common-anode display pins directly.

## Interface
Parameters:
- `DIGITS`, 4, number of scanned digits; fixed at 4, kept for readability only.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rstn`  in  1  reset. Synchronous, active-low.
- `tick_sec`  in  1  one-cycle enable at 1 Hz.
- `tick_scan`  in  1  one-cycle enable at 1 kHz.
- `start_stop`  in  1  one-cycle pulse, already debounced; toggles run/pause.
- `clear`  in  1  one-cycle pulse, already debounced; zeroes the count.
- `an`  out  4  digit enables, active-low; bit 0 is the rightmost digit.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.
- `running`  out  1  high while in state RUN.
- `bcd_time`  out  16  `{min_hi, min_lo, sec_hi, sec_lo}`, 4 bits each.

## Operation
- **States:** IDLE (count zero, stopped), RUN, PAUSE.
- **Transitions:**
  - IDLE + `start_stop` → RUN.
  - RUN + `start_stop` → PAUSE.
  - PAUSE + `start_stop` → RUN.
  - Any state + `clear` → IDLE, with the count set to 00:00.
- **Priority:** `clear` beats `start_stop` in the same cycle; the result is IDLE.
- **Counting:** only when the registered state is RUN and `tick_sec` = 1.
  - A tick in the same cycle as a stop pulse still counts.
  - A tick in the same cycle as a start pulse (from IDLE or PAUSE) does not count.
  - A tick together with `clear` gives 00:00; `clear` wins.
- **Digit ranges:** `sec_lo` 0–9, `sec_hi` 0–5, `min_lo` 0–9, `min_hi` 0–5. Each digit carries into the next.
- **Wrap-around:** 59:59 + tick → 00:00. The state stays RUN; there is no overflow flag.
- **Scan:** a 2-bit digit index increments on `tick_scan` and wraps 3 → 0.
  - Index 0 shows `sec_lo`, 1 `sec_hi`, 2 `min_lo`, 3 `min_hi`.
  - `an` = one-hot-low of the index.
  - `seg` = the decoded value of the selected digit.
  - `dp` = 0 only when the index is 2 and the state is not IDLE; otherwise 1.
- **Segment codes (active-low gfedcba):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Values 10–15 never occur; decode them as 1111111 (blank).
- **No ghosting:** `an`, `seg` and `dp` always change together, on the same edge.

## Timing
- **Reset:** `rstn` is sampled on rising `clk`. While it is low, on each edge:
  - state = IDLE, count = 0000, index = 0;
  - `an` = 1111, `seg` = 1111111, `dp` = 1, `running` = 0, `bcd_time` = 0000.
- **Reset mid-operation:** treated identically to power-up reset; nothing is retained.
- **Output registers:** `an`, `seg` and `dp` are registered from the current index and count.
  - The first edge after `rstn` rises gives `an` = 1110, `seg` = 1000000.
  - A `tick_scan` at edge N advances the index at N; the new `an` appears at edge N+1.
- **Count and status:** `tick_sec` at edge N updates `bcd_time` at edge N, visible after that edge. The displayed digit reflects it one edge later.
- **`running`:** registered; it equals (state == RUN) after the same edge that changes the state.
- **Input pulses:** each high cycle of `start_stop` or `clear` is one event. Multi-cycle pulses are not filtered; filtering is upstream's job.

## Structure
- **Package `seg_pkg`:**
  - state enum `sw_state_t {IDLE, RUN, PAUSE}`;
  - 7-bit segment constants `SEG_0`..`SEG_9` and `SEG_BLANK`;
  - `DIGITS` = 4.
- **Sub-module `bcd_to_seg`:** combinational 4-bit to 7-bit decoder. It is instantiated once, on the selected digit, and its output is registered into `seg` in the top.
- **Top module contains:** the state register, four BCD digit registers with a carry chain, the scan index and the output registers.

## Test plan
- **Reset and idle scan:** hold `rstn` = 0 for 3 cycles, then release, then apply 4 `tick_scan` pulses.
  - During reset: `an` = 1111, `seg` = 1111111.
  - Then `an` cycles 1110 → 1101 → 1011 → 0111 → 1110.
  - `seg` = 1000000 throughout; `dp` = 1 throughout.
- **Run and carry:** pulse `start_stop`, then apply 70 `tick_sec` pulses.
  - `bcd_time` = 0x0110, `running` = 1.
  - With index 2 selected: `seg` = 1111001 and `dp` = 0.
- **Wrap:** run to 59:59 (0x5959), then apply one `tick_sec`.
  - `bcd_time` = 0x0000, `running` still 1.
- **Pause and same-cycle events:**
  - At 0x0012, `start_stop` and `tick_sec` in the same cycle → 0x0013, state PAUSE.
  - Further ticks leave the count at 0x0013.
  - `start_stop` and `tick_sec` in the same cycle → 0x0013, state RUN.
- **Clear priority:** while in RUN at 0x0347, assert `clear`, `start_stop` and `tick_sec` in the same cycle.
  - Result: `bcd_time` = 0x0000, state IDLE, `running` = 0.
  - `dp` = 1 on all digits.
- **Reset mid-run:** at 0x0225, mid-scan at index 3, assert `rstn` = 0 for one cycle.
  - On that edge: all outputs take their reset values.
  - Then `an` = 1110, `seg` = 1000000.
